// File: rtl/stopwatch_bcd_pkg.sv
// Shared types and constants for the BCD stopwatch.
//   state_t : run-control FSM encoding
//   bcd_t   : one BCD digit
//   digit maxima and the default minutes modulus
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t CS_MAX           = 4'd9;  // both centisecond digits
  localparam bcd_t S_ONES_MAX       = 4'd9;
  localparam bcd_t S_TENS_MAX       = 4'd5;
  localparam bcd_t M_DIGIT_MAX      = 4'd9;  // minutes wrap is a 2-digit compare
  localparam int   DEFAULT_MIN_WRAP = 60;

endpackage

// File: rtl/stopwatch_bcd_if.sv
// Control and display bundle for the stopwatch.
//   slave  : stopwatch side (controls in, display/status out)
//   master : driver side (controls out, display/status in)
interface stopwatch_bcd_if;
  import stopwatch_pkg::*;

  logic tick_in;
  logic start_stop;
  logic clear;
  logic lap;
  bcd_t cs_ones;
  bcd_t cs_tens;
  bcd_t s_ones;
  bcd_t s_tens;
  bcd_t m_ones;
  bcd_t m_tens;
  logic running;
  logic lapped;
  logic rollover;

  modport slave (
    input  tick_in, start_stop, clear, lap,
    output cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens,
           running, lapped, rollover
  );

  modport master (
    output tick_in, start_stop, clear, lap,
    input  cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens,
           running, lapped, rollover
  );

endinterface

// File: rtl/stopwatch_bcd_digit_counter.sv
// One BCD digit: counts 0..MAX on en, wraps to 0 and raises carry on the wrap.
//   clock, rst : clock, synchronous active-high reset
//   clr        : synchronous zero, wins over en
//   en         : advance one count
//   q          : digit value
//   carry      : en & (q == MAX), combinational, feeds the next digit's en
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic clock,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output bcd_t q,
  output logic carry
);

  assign carry = en & (q == MAX);

  always_ff @(posedge clock) begin
    if (rst || clr)  q <= '0;
    else if (en)     q <= (q == MAX) ? '0 : q + 4'd1;
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// mm:ss.cc BCD stopwatch advanced by a 100 Hz tick sampled in the clock domain.
//   clock, rst : system clock, synchronous active-high reset
//   bus        : controls (tick_in, start_stop, clear, lap) and
//                display/status (six BCD digits, running, lapped, rollover)
// TICK_IS_LEVEL=1 edge-detects a divided clock; 0 takes tick_in as a pulse.
// MIN_WRAP sets the minutes modulus (2..100).
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter bit TICK_IS_LEVEL = 1'b1,
  parameter int MIN_WRAP      = DEFAULT_MIN_WRAP
) (
  input  logic           clock,
  input  logic           rst,
  stopwatch_bcd_if.slave bus
);

  localparam bcd_t MW_TENS = bcd_t'((MIN_WRAP - 1) / 10);
  localparam bcd_t MW_ONES = bcd_t'((MIN_WRAP - 1) % 10);

  state_t state_q, state_d;
  logic   lapped_q, lapped_d, snap_ld;
  logic   tick_d, tick_p, cnt;
  logic   rollover_q;

  bcd_t cs1, cs10, s1, s10, m1, m10;
  logic c_cs1, c_cs10, c_s1, c_s10, c_m1, c_m10;
  logic min_wrap, m_clr;
  logic [23:0] live, snap_q, disp;

  // tick_d resets low so a tick already high at release reads as an edge
  always_ff @(posedge clock) begin
    if (rst) tick_d <= 1'b0;
    else     tick_d <= bus.tick_in;
  end

  assign tick_p = TICK_IS_LEVEL ? (bus.tick_in & ~tick_d) : bus.tick_in;
  assign cnt    = (state_q == RUN) & tick_p & ~bus.clear;

  // run control and lap freeze
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q  <= IDLE;
      lapped_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lapped_q <= lapped_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lapped_d = lapped_q;
    snap_ld  = 1'b0;
    if (bus.clear) begin
      state_d  = IDLE;
      lapped_d = 1'b0;
    end else begin
      if (bus.start_stop) begin
        case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = STOP;
          STOP:    state_d = RUN;
          default: state_d = IDLE;
        endcase
      end
      if (bus.lap) begin
        if (state_q == RUN) begin
          lapped_d = ~lapped_q;
          snap_ld  = ~lapped_q;
        end else if (state_q == STOP) begin
          lapped_d = 1'b0;
        end
      end
    end
  end

  // digit chain
  bcd_digit_counter #(.MAX(CS_MAX)) u_cs1 (
    .clock(clock), .rst(rst), .clr(bus.clear), .en(cnt),    .q(cs1),  .carry(c_cs1));
  bcd_digit_counter #(.MAX(CS_MAX)) u_cs10 (
    .clock(clock), .rst(rst), .clr(bus.clear), .en(c_cs1),  .q(cs10), .carry(c_cs10));
  bcd_digit_counter #(.MAX(S_ONES_MAX)) u_s1 (
    .clock(clock), .rst(rst), .clr(bus.clear), .en(c_cs10), .q(s1),   .carry(c_s1));
  bcd_digit_counter #(.MAX(S_TENS_MAX)) u_s10 (
    .clock(clock), .rst(rst), .clr(bus.clear), .en(c_s1),   .q(s10),  .carry(c_s10));

  // minutes wrap on a 2-digit compare; clr beats en inside the counters
  assign min_wrap = c_s10 & (m10 == MW_TENS) & (m1 == MW_ONES);
  assign m_clr    = bus.clear | min_wrap;

  bcd_digit_counter #(.MAX(M_DIGIT_MAX)) u_m1 (
    .clock(clock), .rst(rst), .clr(m_clr), .en(c_s10), .q(m1),  .carry(c_m1));
  bcd_digit_counter #(.MAX(M_DIGIT_MAX)) u_m10 (
    .clock(clock), .rst(rst), .clr(m_clr), .en(c_m1),  .q(m10), .carry(c_m10));

  // c_m10 can only fire at 99:59.99 (MIN_WRAP=100), where it equals min_wrap
  always_ff @(posedge clock) begin
    if (rst || bus.clear) rollover_q <= 1'b0;
    else                  rollover_q <= min_wrap | c_m10;
  end

  assign live = {m10, m1, s10, s1, cs10, cs1};

  always_ff @(posedge clock) begin
    if (rst)          snap_q <= '0;
    else if (snap_ld) snap_q <= live;
  end

  assign disp = lapped_q ? snap_q : live;

  assign bus.m_tens   = disp[23:20];
  assign bus.m_ones   = disp[19:16];
  assign bus.s_tens   = disp[15:12];
  assign bus.s_ones   = disp[11:8];
  assign bus.cs_tens  = disp[7:4];
  assign bus.cs_ones  = disp[3:0];
  assign bus.running  = (state_q == RUN);
  assign bus.lapped   = lapped_q;
  assign bus.rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
module tb_stopwatch_bcd;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   ntests = 0;
  int   nfail  = 0;

  always #5 clock = ~clock;

  stopwatch_bcd_if a ();
  stopwatch_bcd_if b ();

  stopwatch_bcd #(.TICK_IS_LEVEL(1'b1), .MIN_WRAP(60)) dut_a (
    .clock(clock), .rst(rst), .bus(a));
  stopwatch_bcd #(.TICK_IS_LEVEL(1'b0), .MIN_WRAP(2)) dut_b (
    .clock(clock), .rst(rst), .bus(b));

  logic [23:0] a_disp, b_disp;
  assign a_disp = {a.m_tens, a.m_ones, a.s_tens, a.s_ones, a.cs_tens, a.cs_ones};
  assign b_disp = {b.m_tens, b.m_ones, b.s_tens, b.s_ones, b.cs_tens, b.cs_ones};

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick_a(input int hi, input int lo);
    a.tick_in = 1'b1;
    repeat (hi) cyc();
    a.tick_in = 1'b0;
    repeat (lo) cyc();
  endtask

  task automatic ss_a();
    a.start_stop = 1'b1; cyc(); a.start_stop = 1'b0;
  endtask

  task automatic lap_a();
    a.lap = 1'b1; cyc(); a.lap = 1'b0;
  endtask

  task automatic clr_a();
    a.clear = 1'b1; cyc(); a.clear = 1'b0;
  endtask

  initial begin
    a.tick_in = 0; a.start_stop = 0; a.clear = 0; a.lap = 0;
    b.tick_in = 0; b.start_stop = 0; b.clear = 0; b.lap = 0;

    // reset
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_digits", a_disp, 24'h000000);
    chk("rst_running", 24'(a.running), 24'd0);
    chk("rst_lapped", 24'(a.lapped), 24'd0);
    chk("rst_rollover", 24'(a.rollover), 24'd0);

    // lap in IDLE is ignored
    lap_a();
    chk("idle_lap", 24'(a.lapped), 24'd0);

    // 100 level ticks 10/10
    ss_a();
    chk("start_running", 24'(a.running), 24'd1);
    a.tick_in = 1'b1;
    cyc();
    chk("first_tick_lat", 24'(a.cs_ones), 24'd1);
    repeat (9) cyc();
    a.tick_in = 1'b0;
    repeat (10) cyc();
    for (int i = 0; i < 99; i++) tick_a(10, 10);
    chk("100_ticks", a_disp, 24'h000100);

    // lap freeze
    clr_a();
    chk("clear_zero", a_disp, 24'h000000);
    ss_a();
    for (int i = 0; i < 37; i++) tick_a(2, 2);
    chk("at_37", a_disp, 24'h000037);
    lap_a();
    chk("lap_set", 24'(a.lapped), 24'd1);
    for (int i = 0; i < 50; i++) tick_a(2, 2);
    chk("lap_frozen", a_disp, 24'h000037);
    lap_a();
    chk("lap_release", 24'(a.lapped), 24'd0);
    chk("lap_live", a_disp, 24'h000087);

    // stop / resume
    clr_a();
    ss_a();
    for (int i = 0; i < 215; i++) tick_a(2, 2);
    chk("at_215", a_disp, 24'h000215);
    ss_a();
    chk("stop_running", 24'(a.running), 24'd0);
    for (int i = 0; i < 20; i++) tick_a(2, 2);
    chk("stop_hold", a_disp, 24'h000215);
    ss_a();
    chk("resume_running", 24'(a.running), 24'd1);
    tick_a(2, 2);
    chk("resume_216", a_disp, 24'h000216);

    // simultaneous controls
    lap_a();
    chk("pre_clr_lapped", 24'(a.lapped), 24'd1);
    a.clear = 1'b1; a.start_stop = 1'b1; a.lap = 1'b1;
    cyc();
    a.clear = 1'b0; a.start_stop = 1'b0; a.lap = 1'b0;
    chk("simul_digits", a_disp, 24'h000000);
    chk("simul_lapped", 24'(a.lapped), 24'd0);
    chk("simul_running", 24'(a.running), 24'd0);
    ss_a();
    a.tick_in = 1'b1; a.start_stop = 1'b1;
    cyc();
    a.start_stop = 1'b0; a.tick_in = 1'b0;
    chk("ss_tick_run_cnt", a_disp, 24'h000001);
    chk("ss_tick_run_stop", 24'(a.running), 24'd0);
    cyc();
    a.tick_in = 1'b1; a.start_stop = 1'b1;
    cyc();
    a.start_stop = 1'b0;
    chk("ss_tick_stop_cnt", a_disp, 24'h000001);
    chk("ss_tick_stop_run", 24'(a.running), 24'd1);
    a.tick_in = 1'b0;
    cyc();
    // a long-held tick counts once
    a.tick_in = 1'b1;
    repeat (30) cyc();
    a.tick_in = 1'b0;
    cyc();
    chk("held_tick_once", a_disp, 24'h000002);

    // lap set in RUN, then cleared by lap in STOP
    lap_a();
    ss_a();
    lap_a();
    chk("stop_lap_clears", 24'(a.lapped), 24'd0);

    // reset mid-run
    clr_a();
    ss_a();
    for (int i = 0; i < 542; i++) tick_a(2, 2);
    chk("at_542", a_disp, 24'h000542);
    a.tick_in = 1'b1; rst = 1'b1;
    cyc();
    chk("midrst_digits", a_disp, 24'h000000);
    chk("midrst_running", 24'(a.running), 24'd0);
    rst = 1'b0;
    cyc();
    ss_a();
    repeat (5) cyc();
    chk("post_rst_held", a_disp, 24'h000000);
    chk("post_rst_running", 24'(a.running), 24'd1);
    a.tick_in = 1'b0;
    cyc();
    a.tick_in = 1'b1;
    cyc();
    chk("post_rst_edge", a_disp, 24'h000001);
    a.tick_in = 1'b0;

    // rollover on the pulse-mode, MIN_WRAP=2 instance
    b.start_stop = 1'b1; cyc(); b.start_stop = 1'b0;
    b.tick_in = 1'b1;
    repeat (6000) cyc();
    chk("b_one_minute", b_disp, 24'h010000);
    repeat (5999) cyc();
    chk("b_at_top", b_disp, 24'h015999);
    chk("b_pre_rollover", 24'(b.rollover), 24'd0);
    cyc();
    b.tick_in = 1'b0;
    chk("b_wrap_digits", b_disp, 24'h000000);
    chk("b_rollover_hi", 24'(b.rollover), 24'd1);
    chk("b_wrap_running", 24'(b.running), 24'd1);
    cyc();
    chk("b_rollover_lo", 24'(b.rollover), 24'd0);
    chk("b_after_wrap", b_disp, 24'h000000);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
Name: stopwatch_bcd

Overview:
- Tick-driven BCD stopwatch that sits directly downstream of the 100 Hz divider.
- Samples the divider output in the system clock domain and does not clock anything from the divided signal.
- Counts mm:ss.cc (minutes 00-59, seconds 00-59, centiseconds 00-99).
- Provides start/stop, clear and lap-freeze controls for the display path.

Parameters:
- TICK_IS_LEVEL, 1: 1 = tick_in is a 50% divided clock and is rising-edge detected internally; 0 = tick_in is already a one-cycle enable pulse.
- MIN_WRAP, 60: minutes modulus. Valid range 2..100.

Ports:
- clock      in   1  system clock; all logic on posedge
- rst        in   1  reset, synchronous, active-high
- tick_in    in   1  100 Hz divider output (level or pulse, per TICK_IS_LEVEL)
- start_stop in   1  one-cycle pulse; toggles run/stop
- clear      in   1  one-cycle pulse; zero the count and return to idle
- lap        in   1  one-cycle pulse; freeze/release the display
- cs_ones    out  4  centiseconds units, BCD
- cs_tens    out  4  centiseconds tens, BCD
- s_ones     out  4  seconds units, BCD
- s_tens     out  4  seconds tens, BCD
- m_ones     out  4  minutes units, BCD
- m_tens     out  4  minutes tens, BCD
- running    out  1  high in RUN
- lapped     out  1  high while the display is frozen
- rollover   out  1  one-cycle pulse when the count wraps to 00:00.00

Behaviour:
- Interface: one clock (clock); reset rst is synchronous and active-high.
- Reset:
  - All digits = 0, state = IDLE.
  - running, lapped and rollover = 0.
  - tick_d = 0, so a tick_in already high at reset release counts as an edge on the first cycle.
- Tick qualify:
  - TICK_IS_LEVEL=1: tick_p = tick_in & ~tick_d, with tick_d registered every cycle.
  - TICK_IS_LEVEL=0: tick_p = tick_in.
  - tick_in held high for N cycles produces exactly one count.
- States:
  - IDLE (count zero, stopped), RUN, STOP (count held, nonzero allowed).
  - start_stop: IDLE->RUN, RUN->STOP, STOP->RUN.
  - clear: any state -> IDLE. Digits zeroed and lapped cleared on the same edge.
  - Priority: rst > clear > start_stop.
- Counting:
  - Counts only when the state is RUN at the sampling edge and tick_p=1.
  - Live digits update on that same edge (latency 1 clock from tick_in rising).
- Same-cycle events:
  - start_stop + tick_p in RUN: the tick is counted and the next state is STOP.
  - start_stop + tick_p in IDLE/STOP: the tick is not counted.
- Carry chain:
  - cs_ones 9->0 carries into cs_tens; cs_tens 9->0 carries into s_ones.
  - s_ones 9->0 carries into s_tens; s_tens 5->0 carries into m_ones.
  - Minutes wrap at MIN_WRAP-1 -> 00.
  - A digit never leaves its legal range. Illegal values are unreachable from reset.
- Rollover:
  - Incrementing MIN_WRAP-1:59.99 gives 00:00.00 with rollover=1 for exactly one cycle.
  - State stays RUN.
- Lap:
  - In RUN, a lap pulse toggles lapped.
  - On the 0->1 transition the live digits are copied to a snapshot register.
  - In STOP, lap clears lapped if set, otherwise it is ignored.
  - In IDLE, lap is ignored.
  - Live counting continues while lapped.
  - clear + lap in the same cycle: clear wins and lapped=0.
- Outputs:
  - Digit outputs = snapshot when lapped=1, else the live registers.
  - All outputs are registered or a mux of registers; no combinational path from inputs.
- Reset mid-RUN: the next edge returns everything to reset values and any in-flight tick is lost.

Decomposition:
- Package stopwatch_pkg:
  - State enum {IDLE, RUN, STOP}.
  - bcd_t (4-bit) typedef.
  - Constants CS_MAX=9/9, S_TENS_MAX=5, DEFAULT_MIN_WRAP=60.
- Sub-module bcd_digit_counter:
  - Parameter MAX.
  - Ports clock, rst, clr, en, q[3:0], carry.
  - carry = en & (q==MAX).
  - Instantiate six, chaining carry->en; minutes use a 2-digit compare against MIN_WRAP-1.

Test Plan:
- Level ticks: reset, start_stop, 100 tick_in rising edges (tick high 10 cycles, low 10 cycles) -> digits 00:01.00; each tick changes cs_ones 1 cycle after the edge.
- Rollover: run to 59:59.99, one more tick -> 00:00.00, rollover high exactly 1 cycle, running=1.
- Lap: run to 00:00.37, lap -> outputs frozen at 00:00.37 for 50 more ticks; lap again -> outputs show live 00:00.87.
- Stop/resume: start_stop at 00:02.15 -> 20 ticks ignored, running=0; start_stop again -> next tick gives 00:02.16.
- Simultaneous controls: clear+start_stop+lap in one cycle during RUN -> IDLE, digits 0, lapped=0, running=0; start_stop+tick in RUN -> tick counted, then STOP.
- Reset mid-run at 00:05.42 with tick_in high -> all outputs 0 next cycle; after release with tick_in still high and TICK_IS_LEVEL=1, the first edge is detected only once.
